// File: rtl/sobel_defs_pkg.sv
// Shared defaults for the Sobel path: pixel width, image size and
// the slot layout of the packed 3x3 window.
package sobel_defs;

    localparam int SOBEL_DATA_W  = 8;
    localparam int SOBEL_LARGURA = 64;
    localparam int SOBEL_ALTURA  = 64;

    // Slot k occupies janela[k*DATA_W +: DATA_W]; p00 sits in the top slot.
    localparam int S00 = 8;
    localparam int S01 = 7;
    localparam int S02 = 6;
    localparam int S10 = 5;
    localparam int S11 = 4;
    localparam int S12 = 3;
    localparam int S20 = 2;
    localparam int S21 = 1;
    localparam int S22 = 0;

    localparam int P00 = S00 * SOBEL_DATA_W;
    localparam int P01 = S01 * SOBEL_DATA_W;
    localparam int P02 = S02 * SOBEL_DATA_W;
    localparam int P10 = S10 * SOBEL_DATA_W;
    localparam int P11 = S11 * SOBEL_DATA_W;
    localparam int P12 = S12 * SOBEL_DATA_W;
    localparam int P20 = S20 * SOBEL_DATA_W;
    localparam int P21 = S21 * SOBEL_DATA_W;
    localparam int P22 = S22 * SOBEL_DATA_W;

    function automatic int win_slot(input int r, input int c);
        return 8 - (3 * r + c);
    endfunction

    function automatic int win_offset(input int r, input int c, input int w);
        return win_slot(r, c) * w;
    endfunction

endpackage

// File: rtl/sobel_buffer_linha.sv
// One image row of storage addressed by column; a read in the same
// cycle as a write to that column returns the previous contents.
module sobel_buffer_linha
    import sobel_defs::*;
#(
    parameter int LARGURA = SOBEL_LARGURA,
    parameter int DATA_W  = SOBEL_DATA_W,
    localparam int ADDR_W = (LARGURA > 1) ? $clog2(LARGURA) : 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // Contents are never reset: rows 0/1 of a frame are masked downstream.
    logic [DATA_W-1:0] mem_q [LARGURA];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

    assign dout = mem_q[addr];

endmodule

// File: rtl/sobel_janela_3x3.sv
// Streaming 3x3 window generator: two line buffers, a shifting window
// register and a single output stage with valid/ready handshake.
module sobel_janela_3x3
    import sobel_defs::*;
#(
    parameter int LARGURA = SOBEL_LARGURA,
    parameter int ALTURA  = SOBEL_ALTURA,
    parameter int DATA_W  = SOBEL_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   pixel_in,
    input  logic                pixel_valid,
    output logic                pixel_ready,
    output logic [9*DATA_W-1:0] janela,
    output logic                janela_valid,
    input  logic                janela_ready,
    output logic                fim_imagem
);

    localparam int COL_W = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam int ROW_W = (ALTURA > 1) ? $clog2(ALTURA) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(LARGURA - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ALTURA - 1);

    logic [COL_W-1:0]         col_q;
    logic [COL_W-1:0]         col_d;
    logic [ROW_W-1:0]         row_q;
    logic [ROW_W-1:0]         row_d;
    logic [8:0][DATA_W-1:0]   win_q;
    logic [8:0][DATA_W-1:0]   win_d;
    logic                     valid_q;
    logic                     valid_d;
    logic                     fim_q;
    logic                     fim_d;

    logic                     acc;
    logic                     last_pix;
    logic                     win_ok;
    logic [DATA_W-1:0]        lb0_rd;
    logic [DATA_W-1:0]        lb1_rd;

    assign pixel_ready = !valid_q || janela_ready;
    assign acc         = pixel_valid && pixel_ready;
    assign last_pix    = (row_q == ROW_MAX) && (col_q == COL_MAX);
    // Columns 0/1 mix the previous row, rows 0/1 hold stale line data.
    assign win_ok      = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    sobel_buffer_linha #(
        .LARGURA (LARGURA),
        .DATA_W  (DATA_W)
    ) u_lb0 (
        .clock (clock),
        .we    (acc),
        .addr  (col_q),
        .din   (pixel_in),
        .dout  (lb0_rd)
    );

    sobel_buffer_linha #(
        .LARGURA (LARGURA),
        .DATA_W  (DATA_W)
    ) u_lb1 (
        .clock (clock),
        .we    (acc),
        .addr  (col_q),
        .din   (lb0_rd),
        .dout  (lb1_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win_d[win_slot(r, 0)] = win_q[win_slot(r, 1)];
                win_d[win_slot(r, 1)] = win_q[win_slot(r, 2)];
            end
            win_d[S02] = lb1_rd;
            win_d[S12] = lb0_rd;
            win_d[S22] = pixel_in;
        end
    end

    always_comb begin
        valid_d = valid_q;
        fim_d   = fim_q;
        if (acc) begin
            valid_d = win_ok;
            fim_d   = last_pix;
        end else if (janela_ready) begin
            valid_d = 1'b0;
            fim_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            fim_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            fim_q   <= fim_d;
        end
    end

    assign janela       = win_q;
    assign janela_valid = valid_q;
    assign fim_imagem   = fim_q;

endmodule

// File: tb/tb_sobel_janela_3x3.sv
// Bench for sobel_janela_3x3: frame-level window model plus directed
// scenarios (back-pressure, gaps, back-to-back frames, reset) and random.
module tb_sobel_janela_3x3;

    localparam int L  = 4;
    localparam int A  = 4;
    localparam int W  = 8;
    localparam int NP = L * A;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   pixel_in = '0;
    logic           pixel_valid = 1'b0;
    logic           pixel_ready;
    logic [9*W-1:0] janela;
    logic           janela_valid;
    logic           janela_ready = 1'b1;
    logic           fim_imagem;

    always #5 clock = ~clock;

    sobel_janela_3x3 #(
        .LARGURA (L),
        .ALTURA  (A),
        .DATA_W  (W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .janela       (janela),
        .janela_valid (janela_valid),
        .janela_ready (janela_ready),
        .fim_imagem   (fim_imagem)
    );

    typedef struct {
        logic [9*W-1:0] win;
        logic           fim;
    } exp_t;

    int             errors = 0;
    int             checks = 0;
    exp_t           exp_q[$];
    logic [9*W-1:0] got_q[$];
    int             fim_cnt = 0;
    int             img[A][L];
    int             pos = 0;
    int             rdy_mode = 0;
    int             stall_left = 0;
    bit             stall_done = 0;

    function automatic logic [9*W-1:0] pack9(
        input int a, input int b, input int c,
        input int d, input int e, input int f,
        input int g, input int h, input int i);
        return {W'(a), W'(b), W'(c), W'(d), W'(e),
                W'(f), W'(g), W'(h), W'(i)};
    endfunction

    task automatic chk(input string name,
                       input logic [9*W-1:0] got,
                       input logic [9*W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)",
                     name, got, want, $time);
        end
    endtask

    // Model: keep the frame as a 2D image, windows are its 3x3 crops.
    always @(negedge clock) begin
        int r;
        int c;
        exp_t e;
        if (reset) begin
            chk("reset_valid", janela_valid, 0);
            chk("reset_fim", fim_imagem, 0);
            chk("reset_janela", janela, 0);
            chk("reset_ready", pixel_ready, 1);
            exp_q.delete();
            pos = 0;
        end else begin
            chk("pixel_ready", pixel_ready,
                !janela_valid || janela_ready);
            chk("janela_valid", janela_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                if (janela_valid) begin
                    chk("janela", janela, exp_q[0].win);
                    chk("fim", fim_imagem, exp_q[0].fim);
                end
            end else begin
                chk("fim_idle", fim_imagem, 0);
            end
            if (janela_valid && janela_ready) begin
                got_q.push_back(janela);
                if (fim_imagem) fim_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (pixel_valid && pixel_ready) begin
                r = pos / L;
                c = pos % L;
                img[r][c] = int'(pixel_in);
                if (r >= 2 && c >= 2) begin
                    e.win = pack9(
                        img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                        img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                        img[r][c-2],   img[r][c-1],   img[r][c]);
                    e.fim = (pos == NP - 1);
                    exp_q.push_back(e);
                end
                pos = (pos == NP - 1) ? 0 : pos + 1;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: janela_ready = 1'b1;
            1: janela_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (stall_left > 0) begin
                    janela_ready = 1'b0;
                    stall_left--;
                end else if (janela_valid && !stall_done) begin
                    janela_ready = 1'b0;
                    stall_left = 2;
                    stall_done = 1'b1;
                end else begin
                    janela_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic send_pix(input int v, input bit gap);
        bit taken;
        int n;
        if (gap) begin
            pixel_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        pixel_in = W'(v);
        pixel_valid = 1'b1;
        taken = 1'b0;
        n = 0;
        while (!taken) begin
            @(negedge clock);
            taken = pixel_ready;
            @(posedge clock);
            #1;
            if (!taken) begin
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: pixel %0d not accepted", v);
                    taken = 1'b1;
                end
            end
        end
    endtask

    task automatic frame(input int base, input bit gap);
        for (int i = 0; i < NP; i++) begin
            send_pix(base + i, gap);
        end
    endtask

    task automatic drain();
        pixel_valid = 1'b0;
        rdy_mode = 0;
        repeat (6) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        got_q.delete();
        fim_cnt = 0;
    endtask

    task automatic check_one_frame(input string tag);
        logic [9*W-1:0] w;
        chk({tag, "_count"}, got_q.size(), 4);
        chk({tag, "_fim_cnt"}, fim_cnt, 1);
        w = got_q[0];
        chk({tag, "_first"}, w, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        w = got_q[1];
        chk({tag, "_second"}, w, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        w = got_q[3];
        chk({tag, "_last"}, w, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    endtask

    initial begin
        logic [9*W-1:0] w;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        clear_log();
        frame(0, 1'b0);
        drain();
        check_one_frame("s1");

        clear_log();
        stall_done = 1'b0;
        stall_left = 0;
        rdy_mode = 2;
        frame(0, 1'b0);
        drain();
        chk("s3_stalled", stall_done, 1);
        check_one_frame("s3");

        clear_log();
        frame(0, 1'b1);
        drain();
        check_one_frame("s4");

        clear_log();
        frame(0, 1'b0);
        frame(100, 1'b0);
        drain();
        chk("s5_count", got_q.size(), 8);
        chk("s5_fim_cnt", fim_cnt, 2);
        w = got_q[4];
        chk("s5_f2_first", w,
            pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));
        w = got_q[7];
        chk("s5_f2_last", w,
            pack9(105, 106, 107, 109, 110, 111, 113, 114, 115));
        for (int k = 4; k < 8; k++) begin
            w = got_q[k];
            for (int b = 0; b < 9; b++) begin
                chk("s5_f2_only", w[b*W +: W] >= 8'd100, 1);
            end
        end

        clear_log();
        for (int i = 0; i < 6; i++) begin
            send_pix(i + 200, 1'b0);
        end
        pixel_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        frame(0, 1'b0);
        drain();
        check_one_frame("s6");

        clear_log();
        for (int f = 0; f < 6; f++) begin
            rdy_mode = 1;
            for (int i = 0; i < NP; i++) begin
                send_pix($urandom_range(0, 255), 1'($urandom_range(0, 1)));
            end
        end
        drain();
        chk("rnd_count", got_q.size(), 24);
        chk("rnd_fim_cnt", fim_cnt, 6);
        chk("rnd_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
